// File: rtl/video_timing_detector.sv
// Purpose: measure sink-side video geometry from decoded hsync/vsync/DE, declare lock, regenerate pixel coordinates.
// Latency: de_in -> pix_valid/pix_x/pix_y 2 clk_in; vsync_in rise -> frame_start 2 clk_in; lock/err visible 1 clk after the edge decision.
// Backpressure: none; this block only observes the stream and never stalls it.
module video_timing_detector #(
    parameter int CNT_W        = 12,
    parameter int LOCK_FRAMES  = 3,
    parameter int EXP_H_TOTAL  = 800,
    parameter int EXP_V_TOTAL  = 525,
    parameter int EXP_H_ACTIVE = 640,
    parameter int EXP_V_ACTIVE = 480
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             de_in,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_active,
    output logic             locked,
    output logic             fmt_match,
    output logic             err_pulse,
    output logic             frame_start,
    output logic             pix_valid,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOCK_N  = CNT_W'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

    state_t           state, state_nxt;
    logic             hs_s1, hs_s2, vs_s1, vs_s2, de_s1, de_s2;
    logic             h_rise, v_rise, de_rise, de_fall;
    logic [CNT_W-1:0] line_cnt, line_len, run_cnt, run_len;
    logic [CNT_W-1:0] frame_lines, frame_de_lines, match_cnt, match_nxt;
    logic [CNT_W-1:0] line_len_now, run_len_now, lines_close, de_lines_close;
    logic             same_as_stored, locked_mismatch, cnt_sat, store, err_nxt;

    // Counters never wrap: they stick at all-ones so a dead input is detectable.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + ONE;
    endfunction

    assign h_rise  = hs_s1 & ~hs_s2;
    assign v_rise  = vs_s1 & ~vs_s2;
    assign de_rise = de_s1 & ~de_s2;
    assign de_fall = ~de_s1 & de_s2;

    // An edge coinciding with vsync rise belongs to the frame that is closing.
    assign line_len_now   = h_rise  ? line_cnt : line_len;
    assign run_len_now    = de_fall ? run_cnt  : run_len;
    assign lines_close    = h_rise  ? sat_inc(frame_lines)    : frame_lines;
    assign de_lines_close = de_rise ? sat_inc(frame_de_lines) : frame_de_lines;

    assign same_as_stored = (line_len_now == h_total) && (run_len_now == h_active) &&
                            (lines_close == v_total) && (de_lines_close == v_active);
    assign locked_mismatch = (h_rise && (line_cnt != h_total)) ||
                             (de_fall && (run_cnt != h_active)) ||
                             (v_rise && ((lines_close != v_total) || (de_lines_close != v_active)));
    assign cnt_sat = (line_cnt == CNT_MAX) || (frame_lines == CNT_MAX);

    assign locked    = (state == LOCKED);
    assign fmt_match = locked &&
                       (h_total  == CNT_W'(EXP_H_TOTAL))  && (v_total  == CNT_W'(EXP_V_TOTAL)) &&
                       (h_active == CNT_W'(EXP_H_ACTIVE)) && (v_active == CNT_W'(EXP_V_ACTIVE));

    // Two-stage input capture; every decision below works on s1/s2 only.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            {hs_s1, hs_s2, vs_s1, vs_s2, de_s1, de_s2} <= '0;
        end else begin
            hs_s1 <= hsync_in;  hs_s2 <= hs_s1;
            vs_s1 <= vsync_in;  vs_s2 <= vs_s1;
            de_s1 <= de_in;     de_s2 <= de_s1;
        end
    end

    // Line, DE-run and per-frame edge counters; frame counters restart on every vsync rise.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            line_cnt       <= '0;
            line_len       <= '0;
            run_cnt        <= '0;
            run_len        <= '0;
            frame_lines    <= '0;
            frame_de_lines <= '0;
        end else begin
            line_cnt <= h_rise ? ONE : sat_inc(line_cnt);
            if (h_rise)
                line_len <= line_cnt;
            if (de_rise)
                run_cnt <= ONE;
            else if (de_s1)
                run_cnt <= sat_inc(run_cnt);
            if (de_fall)
                run_len <= run_cnt;
            if (v_rise)
                frame_lines <= '0;
            else if (h_rise)
                frame_lines <= sat_inc(frame_lines);
            if (v_rise)
                frame_de_lines <= '0;
            else if (de_rise)
                frame_de_lines <= sat_inc(frame_de_lines);
        end
    end

    // Lock FSM next state; a stuck counter overrides everything and only LOCKED reports it as an error.
    always_comb begin
        state_nxt = state;
        match_nxt = match_cnt;
        store     = 1'b0;
        err_nxt   = 1'b0;
        if (cnt_sat) begin
            state_nxt = SEARCH;
            err_nxt   = (state == LOCKED);
        end else begin
            case (state)
                SEARCH: begin
                    if (v_rise)
                        state_nxt = MEASURE;
                end
                MEASURE: begin
                    if (v_rise) begin
                        store     = 1'b1;
                        match_nxt = ONE;
                        state_nxt = (LOCK_FRAMES <= 1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (v_rise) begin
                        if (same_as_stored) begin
                            match_nxt = sat_inc(match_cnt);
                            if (sat_inc(match_cnt) >= LOCK_N)
                                state_nxt = LOCKED;
                        end else begin
                            store     = 1'b1;
                            match_nxt = ONE;
                        end
                    end
                end
                LOCKED: begin
                    if (locked_mismatch) begin
                        state_nxt = SEARCH;
                        err_nxt   = 1'b1;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    // State, match count and stored geometry; stored values survive a drop back to SEARCH.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= SEARCH;
            match_cnt <= '0;
            h_total   <= '0;
            v_total   <= '0;
            h_active  <= '0;
            v_active  <= '0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            match_cnt <= match_nxt;
            err_pulse <= err_nxt;
            if (store) begin
                h_total  <= line_len_now;
                v_total  <= lines_close;
                h_active <= run_len_now;
                v_active <= de_lines_close;
            end
        end
    end

    // Active-area coordinates run regardless of lock state.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            pix_valid   <= de_s1;
            frame_start <= v_rise;
            if (de_rise)
                pix_x <= '0;
            else if (de_s1)
                pix_x <= sat_inc(pix_x);
            if (v_rise)
                pix_y <= '0;
            else if (de_fall)
                pix_y <= sat_inc(pix_y);
        end
    end

endmodule

// File: tb/tb_video_timing_detector.sv
// Purpose: directed checks of lock, error, loss, reset and coordinate behaviour on scaled-down video formats.
// Latency: checks sample 1 time unit after the rising edge; the monitor samples on the falling edge.
// Backpressure: not applicable; the bench drives the stream open-loop.
module tb_video_timing_detector;

    localparam int HT  = 20, HA  = 12, VT  = 10, VA  = 6;   // primary format
    localparam int HT2 = 24, HA2 = 16, VT2 = 12, VA2 = 8;   // alternate format

    logic        clk_in, rst_in, hsync_in, vsync_in, de_in;
    logic [11:0] h_total, v_total, h_active, v_active, pix_x, pix_y;
    logic        locked, fmt_match, err_pulse, frame_start, pix_valid;

    int n_cmp = 0;
    int n_bad = 0;

    video_timing_detector #(
        .CNT_W(12), .LOCK_FRAMES(3),
        .EXP_H_TOTAL(HT), .EXP_V_TOTAL(VT), .EXP_H_ACTIVE(HA), .EXP_V_ACTIVE(VA)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .h_total(h_total), .v_total(v_total), .h_active(h_active), .v_active(v_active),
        .locked(locked), .fmt_match(fmt_match), .err_pulse(err_pulse), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Event monitor: running totals, read by the tests as deltas.
    int   fs_cnt = 0, err_cnt = 0, lock_cnt = 0, lock_at_fs = 0, lock_with_fs = 0;
    int   drop_cnt = 0, drop_err_cnt = 0;
    int   pv_cur = 0, pv_done = 0, fx = 0, fy = 0, lx = 0, ly = 0;
    int   fx_done = 0, fy_done = 0, lx_done = 0, ly_done = 0;
    logic prev_locked = 1'b0;

    always @(negedge clk_in) begin
        if (frame_start) begin
            fs_cnt  = fs_cnt + 1;
            pv_done = pv_cur;
            fx_done = fx; fy_done = fy; lx_done = lx; ly_done = ly;
            pv_cur  = 0;
        end
        if (pix_valid) begin
            if (pv_cur == 0) begin
                fx = int'(pix_x);
                fy = int'(pix_y);
            end
            lx = int'(pix_x);
            ly = int'(pix_y);
            pv_cur = pv_cur + 1;
        end
        if (locked && !prev_locked) begin
            lock_cnt     = lock_cnt + 1;
            lock_at_fs   = fs_cnt;
            lock_with_fs = int'(frame_start);
        end
        if (!locked && prev_locked) begin
            drop_cnt = drop_cnt + 1;
            if (err_pulse)
                drop_err_cnt = drop_err_cnt + 1;
        end
        if (err_pulse)
            err_cnt = err_cnt + 1;
        prev_locked = locked;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        de_in    = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_in = 1'b0;
        repeat (3) tick();
        rst_in = 1'b1;
        tick();
    endtask

    // One frame: DE in lines [0,va) cols [0,ha); hsync at cols ha+2..ha+3; vsync on lines va+2..va+3.
    // long_line gets one extra blank clock; max_cyc >= 0 stops the frame early.
    task automatic drive_frame(input int ht, input int ha, input int vt, input int va,
                               input int long_line, input int max_cyc);
        int n;
        n = 0;
        for (int v = 0; v < vt; v++) begin
            for (int h = 0; h < ht + ((v == long_line) ? 1 : 0); h++) begin
                if (max_cyc >= 0 && n >= max_cyc)
                    return;
                hsync_in = (h >= ha + 2) && (h < ha + 4);
                vsync_in = (v >= va + 2) && (v < va + 4);
                de_in    = (h < ha) && (v < va);
                tick();
                n++;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_in = 1'b0;
        repeat (3) tick();
        n_cmp++; if ({h_total, v_total, h_active, v_active} !== 48'd0) begin n_bad++; $display("FAIL reset geometry: got %h want 0", {h_total, v_total, h_active, v_active}); end
        n_cmp++; if ({locked, fmt_match, err_pulse, frame_start, pix_valid} !== 5'd0) begin n_bad++; $display("FAIL reset flags: got %b want 00000", {locked, fmt_match, err_pulse, frame_start, pix_valid}); end
        n_cmp++; if ({pix_x, pix_y} !== 24'd0) begin n_bad++; $display("FAIL reset coords: got %h want 0", {pix_x, pix_y}); end
        rst_in = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        apply_reset();
        de_in = 1'b1;
        tick();
        n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL lat pv@1: got %b want 0", pix_valid); end
        tick();
        n_cmp++; if (pix_valid !== 1'b1) begin n_bad++; $display("FAIL lat pv@2: got %b want 1", pix_valid); end
        n_cmp++; if ({pix_x, pix_y} !== 24'd0) begin n_bad++; $display("FAIL lat xy@2: got %0d,%0d want 0,0", pix_x, pix_y); end
        de_in = 1'b0;
        tick();
        n_cmp++; if (pix_valid !== 1'b1 || pix_x !== 12'd1) begin n_bad++; $display("FAIL lat x@3: got pv=%b x=%0d want pv=1 x=1", pix_valid, pix_x); end
        tick();
        n_cmp++; if (pix_valid !== 1'b0 || pix_y !== 12'd1) begin n_bad++; $display("FAIL lat y@4: got pv=%b y=%0d want pv=0 y=1", pix_valid, pix_y); end
        vsync_in = 1'b1;
        tick();
        n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL lat fs@1: got %b want 0", frame_start); end
        tick();
        n_cmp++; if (frame_start !== 1'b1 || pix_y !== 12'd0) begin n_bad++; $display("FAIL lat fs@2: got fs=%b y=%0d want fs=1 y=0", frame_start, pix_y); end
        tick();
        n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL lat fs@3: got %b want 0", frame_start); end
        vsync_in = 1'b0;
    endtask

    task automatic test_lock();
        int b_fs, b_lock, b_err;
        apply_reset();
        b_fs = fs_cnt; b_lock = lock_cnt; b_err = err_cnt;
        repeat (5) drive_frame(HT, HA, VT, VA, -1, -1);
        n_cmp++; if (lock_cnt - b_lock !== 1) begin n_bad++; $display("FAIL lock count: got %0d want 1", lock_cnt - b_lock); end
        n_cmp++; if (lock_at_fs - b_fs !== 4) begin n_bad++; $display("FAIL lock vsync index: got %0d want 4", lock_at_fs - b_fs); end
        n_cmp++; if (lock_with_fs !== 1) begin n_bad++; $display("FAIL lock align fs: got %0d want 1", lock_with_fs); end
        n_cmp++; if (fs_cnt - b_fs !== 5) begin n_bad++; $display("FAIL lock fs count: got %0d want 5", fs_cnt - b_fs); end
        n_cmp++; if (err_cnt - b_err !== 0) begin n_bad++; $display("FAIL lock errs: got %0d want 0", err_cnt - b_err); end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock locked: got %b want 1", locked); end
        n_cmp++; if (h_total !== 12'(HT)) begin n_bad++; $display("FAIL lock h_total: got %0d want %0d", h_total, HT); end
        n_cmp++; if (v_total !== 12'(VT)) begin n_bad++; $display("FAIL lock v_total: got %0d want %0d", v_total, VT); end
        n_cmp++; if (h_active !== 12'(HA)) begin n_bad++; $display("FAIL lock h_active: got %0d want %0d", h_active, HA); end
        n_cmp++; if (v_active !== 12'(VA)) begin n_bad++; $display("FAIL lock v_active: got %0d want %0d", v_active, VA); end
        n_cmp++; if (fmt_match !== 1'b1) begin n_bad++; $display("FAIL lock fmt_match: got %b want 1", fmt_match); end
    endtask

    task automatic test_pixels();
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL pix locked: got %b want 1", locked); end
        n_cmp++; if (pv_done !== HA * VA) begin n_bad++; $display("FAIL pix count: got %0d want %0d", pv_done, HA * VA); end
        n_cmp++; if (fx_done !== 0 || fy_done !== 0) begin n_bad++; $display("FAIL pix first: got %0d,%0d want 0,0", fx_done, fy_done); end
        n_cmp++; if (lx_done !== HA - 1 || ly_done !== VA - 1) begin n_bad++; $display("FAIL pix last: got %0d,%0d want %0d,%0d", lx_done, ly_done, HA - 1, VA - 1); end
    endtask

    task automatic test_long_line();
        int b_fs, b_lock, b_err, b_drop, b_derr;
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL long pre-locked: got %b want 1", locked); end
        b_fs = fs_cnt; b_lock = lock_cnt; b_err = err_cnt; b_drop = drop_cnt; b_derr = drop_err_cnt;
        drive_frame(HT, HA, VT, VA, 1, -1);
        n_cmp++; if (err_cnt - b_err !== 1) begin n_bad++; $display("FAIL long err pulses: got %0d want 1", err_cnt - b_err); end
        n_cmp++; if (drop_cnt - b_drop !== 1 || drop_err_cnt - b_derr !== 1) begin n_bad++; $display("FAIL long drop with err: got drops=%0d with_err=%0d want 1,1", drop_cnt - b_drop, drop_err_cnt - b_derr); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL long unlocked: got %b want 0", locked); end
        repeat (4) drive_frame(HT, HA, VT, VA, -1, -1);
        n_cmp++; if (lock_cnt - b_lock !== 1 || lock_at_fs - b_fs !== 4) begin n_bad++; $display("FAIL long relock: got locks=%0d at_vsync=%0d want 1,4", lock_cnt - b_lock, lock_at_fs - b_fs); end
        n_cmp++; if (locked !== 1'b1 || fmt_match !== 1'b1) begin n_bad++; $display("FAIL long final: got locked=%b fmt=%b want 1,1", locked, fmt_match); end
    endtask

    task automatic test_idle_loss();
        int b_fs, b_lock, b_err, b_drop, b_derr;
        b_err = err_cnt; b_drop = drop_cnt; b_derr = drop_err_cnt;
        idle_inputs();
        repeat (4000) tick();
        n_cmp++; if (locked !== 1'b1 || err_cnt - b_err !== 0) begin n_bad++; $display("FAIL idle early: got locked=%b errs=%0d want 1,0", locked, err_cnt - b_err); end
        repeat (100) tick();
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL idle unlocked: got %b want 0", locked); end
        n_cmp++; if (err_cnt - b_err !== 1) begin n_bad++; $display("FAIL idle err pulses: got %0d want 1", err_cnt - b_err); end
        n_cmp++; if (drop_cnt - b_drop !== 1 || drop_err_cnt - b_derr !== 1) begin n_bad++; $display("FAIL idle drop with err: got %0d,%0d want 1,1", drop_cnt - b_drop, drop_err_cnt - b_derr); end
        n_cmp++; if (h_total !== 12'(HT) || v_active !== 12'(VA)) begin n_bad++; $display("FAIL idle kept geometry: got %0d,%0d want %0d,%0d", h_total, v_active, HT, VA); end
        b_fs = fs_cnt; b_lock = lock_cnt;
        repeat (5) drive_frame(HT, HA, VT, VA, -1, -1);
        n_cmp++; if (lock_cnt - b_lock !== 1 || lock_at_fs - b_fs !== 4) begin n_bad++; $display("FAIL idle relock: got locks=%0d at_vsync=%0d want 1,4", lock_cnt - b_lock, lock_at_fs - b_fs); end
    endtask

    task automatic test_mid_reset();
        int b_fs, b_lock;
        drive_frame(HT, HA, VT, VA, -1, 2 * HT + 6);
        n_cmp++; if (pix_valid !== 1'b1 || locked !== 1'b1) begin n_bad++; $display("FAIL mid pre: got pv=%b locked=%b want 1,1", pix_valid, locked); end
        rst_in = 1'b0;
        #1;
        n_cmp++; if ({h_total, v_total, h_active, v_active} !== 48'd0) begin n_bad++; $display("FAIL mid geometry: got %h want 0", {h_total, v_total, h_active, v_active}); end
        n_cmp++; if ({locked, fmt_match, err_pulse, frame_start, pix_valid} !== 5'd0) begin n_bad++; $display("FAIL mid flags: got %b want 00000", {locked, fmt_match, err_pulse, frame_start, pix_valid}); end
        n_cmp++; if ({pix_x, pix_y} !== 24'd0) begin n_bad++; $display("FAIL mid coords: got %h want 0", {pix_x, pix_y}); end
        idle_inputs();
        repeat (2) tick();
        rst_in = 1'b1;
        tick();
        b_fs = fs_cnt; b_lock = lock_cnt;
        repeat (5) drive_frame(HT, HA, VT, VA, -1, -1);
        n_cmp++; if (lock_cnt - b_lock !== 1 || lock_at_fs - b_fs !== 4) begin n_bad++; $display("FAIL mid relock: got locks=%0d at_vsync=%0d want 1,4", lock_cnt - b_lock, lock_at_fs - b_fs); end
        n_cmp++; if (h_total !== 12'(HT) || v_total !== 12'(VT)) begin n_bad++; $display("FAIL mid geometry back: got %0d,%0d want %0d,%0d", h_total, v_total, HT, VT); end
    endtask

    task automatic test_alt_format();
        int b_fs, b_lock, b_err;
        b_fs = fs_cnt; b_lock = lock_cnt; b_err = err_cnt;
        repeat (5) drive_frame(HT2, HA2, VT2, VA2, -1, -1);
        n_cmp++; if (err_cnt - b_err !== 1) begin n_bad++; $display("FAIL alt err pulses: got %0d want 1", err_cnt - b_err); end
        n_cmp++; if (lock_cnt - b_lock !== 1 || lock_at_fs - b_fs !== 4) begin n_bad++; $display("FAIL alt relock: got locks=%0d at_vsync=%0d want 1,4", lock_cnt - b_lock, lock_at_fs - b_fs); end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL alt locked: got %b want 1", locked); end
        n_cmp++; if (h_total !== 12'(HT2)) begin n_bad++; $display("FAIL alt h_total: got %0d want %0d", h_total, HT2); end
        n_cmp++; if (v_total !== 12'(VT2)) begin n_bad++; $display("FAIL alt v_total: got %0d want %0d", v_total, VT2); end
        n_cmp++; if (h_active !== 12'(HA2)) begin n_bad++; $display("FAIL alt h_active: got %0d want %0d", h_active, HA2); end
        n_cmp++; if (v_active !== 12'(VA2)) begin n_bad++; $display("FAIL alt v_active: got %0d want %0d", v_active, VA2); end
        n_cmp++; if (fmt_match !== 1'b0) begin n_bad++; $display("FAIL alt fmt_match: got %b want 0", fmt_match); end
        n_cmp++; if (pv_done !== HA2 * VA2 || lx_done !== HA2 - 1 || ly_done !== VA2 - 1) begin n_bad++; $display("FAIL alt pixels: got n=%0d last=%0d,%0d want %0d last=%0d,%0d", pv_done, lx_done, ly_done, HA2 * VA2, HA2 - 1, VA2 - 1); end
    endtask

    initial begin
        idle_inputs();
        rst_in = 1'b0;
        test_reset();
        test_latency();
        test_lock();
        test_pixels();
        test_long_line();
        test_idle_loss();
        test_mid_reset();
        test_alt_format();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
